// File: rtl/hist_pkg.sv
// Shared types and width checks for the histogram_stream block.
// Optional saturating counters are enabled with the HIST_SATURATE_EN macro.
`ifndef HIST_PKG_SV
`define HIST_PKG_SV

package hist_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    FLUSH   = 2'd1,
    READOUT = 2'd2
  } hist_state_t;

  // Legal geometry: at least one bin bit, bin index taken from the sample MSBs,
  // and a non-empty counter.
  function automatic bit hist_widths_ok(input int data_w, input int bin_bits,
                                        input int count_w);
    return (bin_bits >= 1) && (bin_bits <= data_w) && (count_w >= 1);
  endfunction

endpackage

// Elaboration-time guard placed inside modules that use the geometry.
`define HIST_ELAB_CHECK(DW, BB, CW) \
  if (!hist_pkg::hist_widths_ok(DW, BB, CW)) begin : g_width_check \
    $error("histogram_stream: need 1 <= C_BIN_BITS <= C_DATA_WIDTH and C_COUNT_WIDTH >= 1"); \
  end

`endif

// File: rtl/histogram_stream_if.sv
// Pixel-in / bin-count-out handshake bundle for histogram_stream.
// slave: the histogram block; master: pixel source plus readout consumer.
interface histogram_stream_if #(
  parameter int C_DATA_WIDTH  = 8,
  parameter int C_BIN_BITS    = 4,
  parameter int C_COUNT_WIDTH = 16
);
  logic                     valid_i;
  logic                     ready_o;
  logic [C_DATA_WIDTH-1:0]  data_i;
  logic                     last_i;
  logic                     m_valid_o;
  logic                     m_ready_i;
  logic [C_BIN_BITS-1:0]    m_bin_o;
  logic [C_COUNT_WIDTH-1:0] m_data_o;
  logic                     m_last_o;

  modport slave (
    input  valid_i, data_i, last_i, m_ready_i,
    output ready_o, m_valid_o, m_bin_o, m_data_o, m_last_o
  );

  modport master (
    output valid_i, data_i, last_i, m_ready_i,
    input  ready_o, m_valid_o, m_bin_o, m_data_o, m_last_o
  );
endinterface

// File: rtl/hist_bin_counter.sv
// One histogram bin: increment, clear-on-readout, optional saturation
// (HIST_SATURATE_EN), otherwise wraps modulo 2^C_COUNT_WIDTH.
module hist_bin_counter #(
  parameter int C_COUNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     inc_i,
  input  logic                     clr_i,
  output logic [C_COUNT_WIDTH-1:0] cnt_o
`ifdef HIST_SATURATE_EN
  ,
  output logic                     sat_evt_o
`endif
);

`ifdef HIST_SATURATE_EN
  localparam logic [C_COUNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [C_COUNT_WIDTH-1:0] next_count(input logic [C_COUNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // An increment that finds the counter already full is a saturation event.
  assign sat_evt_o = inc_i && !clr_i && (cnt_o == CNT_MAX);
`else
  function automatic logic [C_COUNT_WIDTH-1:0] next_count(input logic [C_COUNT_WIDTH-1:0] c);
    return c + 1'b1;
  endfunction
`endif

  // Clear wins over increment; increments never coincide with readout anyway.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
    end else if (inc_i) begin
      cnt_o <= next_count(cnt_o);
    end
  end

endmodule

// File: rtl/histogram_stream.sv
// Streaming histogram: bins pixel MSBs, and on the frame's last beat streams
// every bin count out over a valid/ready port, clearing each bin as it goes.
// Optional macro HIST_SATURATE_EN: saturating bins plus sticky sat_o port.
module histogram_stream #(
  parameter int C_DATA_WIDTH  = 8,
  parameter int C_BIN_BITS    = 4,
  parameter int C_COUNT_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  histogram_stream_if.slave  s
`ifdef HIST_SATURATE_EN
  ,
  output logic               sat_o
`endif
);

  import hist_pkg::*;

  `HIST_ELAB_CHECK(C_DATA_WIDTH, C_BIN_BITS, C_COUNT_WIDTH)

  localparam int                    NBINS    = 1 << C_BIN_BITS;
  localparam logic [C_BIN_BITS-1:0] LAST_BIN = '1;

  hist_state_t              state_q, state_d;
  logic [C_BIN_BITS-1:0]    ptr_q, ptr_d;
  logic                     accept;
  logic                     rd_hs;
  logic                     vld_p1;
  logic                     last_p1;
  logic [C_BIN_BITS-1:0]    idx_p1;
  logic [C_COUNT_WIDTH-1:0] cnt [NBINS];
  logic                     unused_data_lsbs;
`ifdef HIST_SATURATE_EN
  logic [NBINS-1:0]         sat_vec;
`endif

  // Only the MSBs select a bin; the remaining sample bits are intentionally dropped.
  assign unused_data_lsbs = ^s.data_i;

  assign accept = s.valid_i && s.ready_o;
  assign rd_hs  = (state_q == READOUT) && s.m_ready_i;

  // Stage 1: register bin index and frame-end flag of each accepted beat
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
    end
    if (accept) begin
      idx_p1  <= s.data_i[C_DATA_WIDTH-1 -: C_BIN_BITS];
      last_p1 <= s.last_i;
    end
  end

  // Stage 2: the addressed bin counts the beat; readout clears the bin it hands over
  for (genvar b = 0; b < NBINS; b++) begin : g_bin
    logic inc_b;
    logic clr_b;

    assign inc_b = vld_p1 && (idx_p1 == C_BIN_BITS'(b));
    assign clr_b = rd_hs && (ptr_q == C_BIN_BITS'(b));

    hist_bin_counter #(
      .C_COUNT_WIDTH (C_COUNT_WIDTH)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc_i     (inc_b),
      .clr_i     (clr_b),
      .cnt_o     (cnt[b])
`ifdef HIST_SATURATE_EN
      ,
      .sat_evt_o (sat_vec[b])
`endif
    );
  end

  // FSM state and read pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state, readout mux and handshake outputs. Input is refused while the
  // last beat sits in stage 1 so the next frame cannot leak into this readout.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    s.ready_o   = 1'b0;
    s.m_valid_o = 1'b0;
    s.m_bin_o   = '0;
    s.m_data_o  = '0;
    s.m_last_o  = 1'b0;
    unique case (state_q)
      ACCUM: begin
        s.ready_o = !(vld_p1 && last_p1);
        if (vld_p1 && last_p1) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = READOUT;
        ptr_d   = '0;
      end
      READOUT: begin
        s.m_valid_o = 1'b1;
        s.m_bin_o   = ptr_q;
        s.m_data_o  = cnt[ptr_q];
        s.m_last_o  = (ptr_q == LAST_BIN);
        if (rd_hs) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LAST_BIN) begin
            state_d = ACCUM;
          end
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

`ifdef HIST_SATURATE_EN
  // Sticky saturation flag, dropped once the final bin has been handed over
  always_ff @(posedge clk_i) begin
    if (rst_i || (rd_hs && (ptr_q == LAST_BIN))) begin
      sat_o <= 1'b0;
    end else if (|sat_vec) begin
      sat_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_histogram_stream.sv
// Bench for histogram_stream: randomized frames against a count-per-bin model,
// plus a narrow-counter instance for the overflow behaviour.
module tb_histogram_stream;

  localparam int DW   = 8;
  localparam int BB   = 4;
  localparam int NB   = 1 << BB;
  localparam int CW   = 16;
  localparam int CW_B = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  histogram_stream_if #(.C_DATA_WIDTH(DW), .C_BIN_BITS(BB), .C_COUNT_WIDTH(CW))   a_if ();
  histogram_stream_if #(.C_DATA_WIDTH(DW), .C_BIN_BITS(BB), .C_COUNT_WIDTH(CW_B)) b_if ();

`ifdef HIST_SATURATE_EN
  logic sat_a;
  logic sat_b;
`endif

  histogram_stream #(
    .C_DATA_WIDTH (DW), .C_BIN_BITS (BB), .C_COUNT_WIDTH (CW)
  ) u_dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .s     (a_if)
`ifdef HIST_SATURATE_EN
    ,
    .sat_o (sat_a)
`endif
  );

  histogram_stream #(
    .C_DATA_WIDTH (DW), .C_BIN_BITS (BB), .C_COUNT_WIDTH (CW_B)
  ) u_dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .s     (b_if)
`ifdef HIST_SATURATE_EN
    ,
    .sat_o (sat_b)
`endif
  );

  int total = 0;
  int bad   = 0;
  int model [NB];
  byte unsigned beats [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) model[i] = 0;
  endtask

  // Offer every beat of the queue to DUT a; gap_pct is the chance of idling a cycle.
  task automatic send_frame(input int gap_pct);
    int   i     = 0;
    int   guard = 0;
    logic v;
    logic acc;
    while (i < beats.size() && guard < 4000) begin
      v = ($urandom_range(99) >= gap_pct);
      a_if.valid_i = v;
      a_if.data_i  = beats[i];
      a_if.last_i  = (i == beats.size() - 1);
      acc = v && a_if.ready_o;
      step();
      guard++;
      if (acc) begin
        model[beats[i] / (1 << (DW - BB))] = (model[beats[i] / (1 << (DW - BB))] + 1) % (1 << CW);
        i++;
      end
    end
    a_if.valid_i = 1'b0;
    a_if.last_i  = 1'b0;
    if (i < beats.size()) check("send_timeout", i, beats.size());
  endtask

  // Drain all bins from DUT a; mode 0 = always ready, mode 1 = ready pattern 1,0,0.
  task automatic read_frame(input int mode, input string tag);
    int   k   = 0;
    int   cyc = 0;
    logic r;
    while (k < NB && cyc < 400) begin
      r = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      a_if.m_ready_i = r;
      if (a_if.m_valid_o) begin
        check({tag, "_ready_o"}, a_if.ready_o, 0);
        check({tag, "_bin"}, a_if.m_bin_o, k);
        check({tag, "_data"}, a_if.m_data_o, model[k]);
        check({tag, "_last"}, a_if.m_last_o, (k == NB - 1));
        if (r) begin
          model[k] = 0;
          k++;
        end
      end
      step();
      cyc++;
    end
    a_if.m_ready_i = 1'b1;
    if (k < NB) check({tag, "_timeout"}, k, NB);
    check({tag, "_end_valid"}, a_if.m_valid_o, 0);
    check({tag, "_end_ready"}, a_if.ready_o, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int cyc;
    int exp_b;

    a_if.valid_i = 1'b0; a_if.data_i = '0; a_if.last_i = 1'b0; a_if.m_ready_i = 1'b1;
    b_if.valid_i = 1'b0; b_if.data_i = '0; b_if.last_i = 1'b0; b_if.m_ready_i = 1'b1;
    clear_model();

    // Reset then idle
    rst = 1'b1;
    repeat (3) step();
    check("rst_m_valid", a_if.m_valid_o, 0);
    check("rst_m_bin", a_if.m_bin_o, 0);
    check("rst_m_data", a_if.m_data_o, 0);
    check("rst_m_last", a_if.m_last_o, 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      check("idle_m_valid", a_if.m_valid_o, 0);
      check("idle_ready", a_if.ready_o, 1);
      step();
    end
`ifdef HIST_SATURATE_EN
    check("rst_sat_b", sat_b, 0);
`endif

    // Basic frame with first-word latency check
    beats = '{8'h00, 8'h15, 8'h1F, 8'hF0};
    send_frame(0);
    check("lat_e0_valid", a_if.m_valid_o, 0);
    check("lat_e0_ready", a_if.ready_o, 0);
    step();
    check("lat_e1_valid", a_if.m_valid_o, 0);
    check("lat_e1_ready", a_if.ready_o, 0);
    step();
    check("lat_e2_valid", a_if.m_valid_o, 1);
    read_frame(0, "basic");
`ifdef HIST_SATURATE_EN
    check("basic_sat_a", sat_a, 0);
`endif

    // Same-bin burst with random input gaps
    beats.delete();
    repeat (100) beats.push_back(8'h3A);
    send_frame(50);
    read_frame(0, "burst");

    // Output backpressure, then confirm bins were cleared on readout
    beats.delete();
    repeat (40) beats.push_back(8'($urandom_range(255)));
    send_frame(30);
    read_frame(1, "bp");
    beats.delete();
    repeat (25) beats.push_back(8'($urandom_range(255)));
    send_frame(0);
    read_frame(0, "post_bp");

    // Reset in the middle of readout
    beats.delete();
    repeat (20) beats.push_back(8'($urandom_range(255)));
    send_frame(0);
    k = 0;
    cyc = 0;
    a_if.m_ready_i = 1'b1;
    while (k < 6 && cyc < 100) begin
      if (a_if.m_valid_o) begin
        check("mid_bin", a_if.m_bin_o, k);
        check("mid_data", a_if.m_data_o, model[k]);
        k++;
      end
      step();
      cyc++;
    end
    if (k < 6) check("mid_timeout", k, 6);
    rst = 1'b1;
    step();
    check("mid_rst_m_valid", a_if.m_valid_o, 0);
    rst = 1'b0;
    step();
    clear_model();
    beats = '{8'h80};
    send_frame(0);
    read_frame(0, "after_rst");

    // Overflow on the narrow-counter instance: 20 beats into bin 0
`ifdef HIST_SATURATE_EN
    exp_b = (20 > (1 << CW_B) - 1) ? (1 << CW_B) - 1 : 20;
`else
    exp_b = 20 % (1 << CW_B);
`endif
    for (int i = 0; i < 20; i++) begin
      b_if.valid_i = 1'b1;
      b_if.data_i  = 8'h00;
      b_if.last_i  = (i == 19);
      check("ovf_ready", b_if.ready_o, 1);
      step();
    end
    b_if.valid_i = 1'b0;
    b_if.last_i  = 1'b0;
    cyc = 0;
    while (!b_if.m_valid_o && cyc < 20) begin
      step();
      cyc++;
    end
    for (int i = 0; i < NB; i++) begin
      check("ovf_valid", b_if.m_valid_o, 1);
      check("ovf_bin", b_if.m_bin_o, i);
      check("ovf_data", b_if.m_data_o, (i == 0) ? exp_b : 0);
      check("ovf_last", b_if.m_last_o, (i == NB - 1));
`ifdef HIST_SATURATE_EN
      check("ovf_sat_held", sat_b, 1);
`endif
      step();
    end
    check("ovf_end_valid", b_if.m_valid_o, 0);
`ifdef HIST_SATURATE_EN
    check("ovf_sat_cleared", sat_b, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
